// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: bubble encoding,
// next-PC select codes and fetch state encodings.
// Imported by fetch_unit and next_pc_gen.
package fetch_unit_pkg;

  // addi x0,x0,0 -- the canonical bubble
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // next_PC_select encodings; 2'b11 falls back to sequential
  localparam logic [1:0] SEL_SEQ    = 2'b00;
  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_JALR   = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_next_pc_gen.sv
// Combinational next-PC select: PC+4, branch target, JALR target or vector.
// Zero latency; no flow control of its own (caller decides when to load).
// PC arithmetic wraps modulo 2^ADDRESS_BITS; targets pass through unmodified.
module next_pc_gen
  import fetch_unit_pkg::*;
#(
  parameter int                      ADDRESS_BITS = 20,
  parameter logic [ADDRESS_BITS-1:0] INT_VECTOR   = 'h100
) (
  input  logic [ADDRESS_BITS-1:0] pc_i,
  input  logic [1:0]              select_i,
  input  logic [ADDRESS_BITS-1:0] branch_target_i,
  input  logic [ADDRESS_BITS-1:0] jalr_target_i,
  input  logic                    take_int_i,
  output logic [ADDRESS_BITS-1:0] resume_pc_o,
  output logic                    redirect_o,
  output logic [ADDRESS_BITS-1:0] next_pc_o
);

  // Resume address ignores the interrupt; the vector overrides it for the PC
  always_comb begin
    resume_pc_o = pc_i + ADDRESS_BITS'(4);
    redirect_o  = 1'b0;
    case (select_i)
      SEL_BRANCH: begin
        resume_pc_o = branch_target_i;
        redirect_o  = 1'b1;
      end
      SEL_JALR: begin
        resume_pc_o = jalr_target_i;
        redirect_o  = 1'b1;
      end
      default: ;
    endcase
    next_pc_o = take_int_i ? INT_VECTOR : resume_pc_o;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues synchronous imem reads, squashes wrong-path words.
// Data appears one cycle after an accepted request, aligned with the next registered PC.
// stall holds the PC and re-issues; i_mem_ready=0 holds the PC and raises fetch_stall.
// Optional: define FETCH_PERF_CNT_EN to build the fetched/squashed performance counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                      DATA_WIDTH   = 32,
  parameter int                      ADDRESS_BITS = 20,
  parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0,
  parameter logic [ADDRESS_BITS-1:0] INT_VECTOR   = 'h100,
  parameter logic [DATA_WIDTH-1:0]   NOP          = DATA_WIDTH'(NOP_INSTR)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDRESS_BITS-1:0] program_address,
  input  logic                    stall,
  input  logic [1:0]              next_PC_select,
  input  logic [ADDRESS_BITS-1:0] branch_target,
  input  logic [ADDRESS_BITS-1:0] jalr_target,
  input  logic                    interrupt_request,
  output logic                    i_mem_req,
  output logic [ADDRESS_BITS-1:0] i_mem_addr,
  input  logic                    i_mem_ready,
  input  logic [DATA_WIDTH-1:0]   i_mem_data,
  output logic [DATA_WIDTH-1:0]   instruction_fetch,
  output logic [ADDRESS_BITS-1:0] inst_PC_fetch,
  output logic                    interrupt_trigger_fetch,
  output logic [ADDRESS_BITS-1:0] interrupt_return_PC,
  output logic                    fetch_stall,
  output logic [31:0]             fetched_count,
  output logic [31:0]             squashed_count
);

  fetch_state_e            state_q, state_d;
  logic [ADDRESS_BITS-1:0] pc_q, pc_d;
  logic [ADDRESS_BITS-1:0] int_ret_q, int_ret_d;
  logic                    pending_q, pending_d;
  logic                    squash_q, squash_d;
  logic                    valid_q, valid_d;
  logic                    int_trig_q, int_trig_d;

  logic                    run;
  logic                    take_int;
  logic                    redirect;
  logic [ADDRESS_BITS-1:0] resume_pc;
  logic [ADDRESS_BITS-1:0] next_pc;

  assign run      = (state_q == RUN);
  // Interrupts are only taken on a cycle where the PC would actually advance
  assign take_int = run & ~stall & i_mem_ready & pending_q;

  next_pc_gen #(
    .ADDRESS_BITS (ADDRESS_BITS),
    .INT_VECTOR   (INT_VECTOR)
  ) u_next_pc_gen (
    .pc_i            (pc_q),
    .select_i        (next_PC_select),
    .branch_target_i (branch_target),
    .jalr_target_i   (jalr_target),
    .take_int_i      (take_int),
    .resume_pc_o     (resume_pc),
    .redirect_o      (redirect),
    .next_pc_o       (next_pc)
  );

  // Next-state logic: IDLE waits for start, RUN advances the PC by priority
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    int_ret_d  = int_ret_q;
    pending_d  = pending_q;
    squash_d   = 1'b0;
    valid_d    = run & i_mem_ready;
    int_trig_d = 1'b0;
    case (state_q)
      IDLE: begin
        pc_d = RESET_PC;
        if (start) begin
          state_d = RUN;
          pc_d    = program_address;
        end
      end
      RUN: begin
        if (interrupt_request) pending_d = 1'b1;
        if (stall || !i_mem_ready) begin
          pc_d = pc_q;
        end else if (take_int) begin
          // A request arriving in the same cycle is dropped: pending clears
          pc_d       = next_pc;
          int_ret_d  = resume_pc;
          pending_d  = 1'b0;
          squash_d   = 1'b1;
          int_trig_d = 1'b1;
        end else begin
          pc_d     = next_pc;
          squash_d = redirect;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and control registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      int_ret_q  <= '0;
      pending_q  <= 1'b0;
      squash_q   <= 1'b0;
      valid_q    <= 1'b0;
      int_trig_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      int_ret_q  <= int_ret_d;
      pending_q  <= pending_d;
      squash_q   <= squash_d;
      valid_q    <= valid_d;
      int_trig_q <= int_trig_d;
    end
  end

  assign i_mem_req               = run;
  assign i_mem_addr              = pc_q;
  assign inst_PC_fetch           = pc_q;
  assign fetch_stall             = run & ~i_mem_ready;
  assign interrupt_trigger_fetch = int_trig_q;
  assign interrupt_return_PC     = int_ret_q;
  assign instruction_fetch       = (valid_q && !squash_q) ? i_mem_data : NOP;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, squashed_q;

  // Performance counters: presented instructions and squashed words
  always_ff @(posedge clock) begin
    if (reset) begin
      fetched_q  <= '0;
      squashed_q <= '0;
    end else begin
      if (valid_q && !squash_q && !stall) fetched_q  <= fetched_q + 32'd1;
      if (valid_q && squash_q)            squashed_q <= squashed_q + 32'd1;
    end
  end

  assign fetched_count  = fetched_q;
  assign squashed_count = squashed_q;
`else
  assign fetched_count  = 32'd0;
  assign squashed_count = 32'd0;
`endif

endmodule
